// File: rtl/rggen_request_demux.sv
// Routes one upstream request to a one-hot selected downstream target and returns
// that target's response upstream; a single transaction is in flight at a time.
module rggen_request_demux #(
  parameter int WIDTH      = 32,
  parameter int RESP_WIDTH = 32,
  parameter int ENTRIES    = 2,
  parameter int TIMEOUT    = 0
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_request_valid,
  output logic                                  o_request_ready,
  input  logic [ENTRIES-1:0]                    i_select,
  input  logic [WIDTH-1:0]                      i_request_data,
  output logic [ENTRIES-1:0]                    o_valid,
  input  logic [ENTRIES-1:0]                    i_ready,
  output logic [WIDTH-1:0]                      o_data,
  input  logic [ENTRIES-1:0]                    i_response_valid,
  input  logic [ENTRIES-1:0][RESP_WIDTH-1:0]    i_response_data,
  output logic                                  o_response_valid,
  input  logic                                  i_response_ready,
  output logic [RESP_WIDTH-1:0]                 o_response_data,
  output logic                                  o_response_error
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_SAT  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '0;

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, RESPONSE} state_t;

  state_t                  state_reg;
  logic [ENTRIES-1:0]      sel_reg;
  logic [ENTRIES-1:0]      valid_reg;
  logic [WIDTH-1:0]        data_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    resp_valid_reg;
  logic [RESP_WIDTH-1:0]   resp_data_reg;
  logic                    resp_err_reg;

  logic                    select_onehot;
  logic                    sel_ready;
  logic                    sel_resp_valid;
  logic                    timeout_hit;
  logic [RESP_WIDTH-1:0]   sel_resp_data;
  logic [ENTRIES-1:0][RESP_WIDTH-1:0] masked_resp;

  assign select_onehot  = (i_select != '0) && ((i_select & (i_select - ENTRIES'(1))) == '0);
  assign sel_ready      = |(i_ready & sel_reg);
  assign sel_resp_valid = |(i_response_valid & sel_reg);
  assign timeout_hit    = (TIMEOUT > 0) && (cnt_reg == CNT_LAST);

  // Only the captured target's response lane survives the AND-OR reduction.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_mask
    assign masked_resp[gi] = sel_reg[gi] ? i_response_data[gi] : '0;
  end

  always_comb begin
    sel_resp_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      sel_resp_data = sel_resp_data | masked_resp[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      sel_reg        <= '0;
      valid_reg      <= '0;
      data_reg       <= '0;
      cnt_reg        <= '0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      if ((state_reg == REQUEST || state_reg == WAIT) && TIMEOUT > 0 && cnt_reg != CNT_SAT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (i_request_valid) begin
            sel_reg  <= i_select;
            data_reg <= i_request_data;
            cnt_reg  <= '0;
            if (select_onehot) begin
              state_reg <= REQUEST;
              valid_reg <= i_select;
            end else begin
              state_reg      <= RESPONSE;
              resp_valid_reg <= 1'b1;
              resp_data_reg  <= '0;
              resp_err_reg   <= 1'b1;
            end
          end
        end
        REQUEST: begin
          // A completion in the timeout cycle takes priority over the error.
          if (sel_ready && sel_resp_valid) begin
            valid_reg      <= '0;
            state_reg      <= RESPONSE;
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= sel_resp_data;
            resp_err_reg   <= 1'b0;
          end else if (timeout_hit) begin
            valid_reg      <= '0;
            state_reg      <= RESPONSE;
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b1;
          end else if (sel_ready) begin
            valid_reg <= '0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (sel_resp_valid) begin
            state_reg      <= RESPONSE;
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= sel_resp_data;
            resp_err_reg   <= 1'b0;
          end else if (timeout_hit) begin
            state_reg      <= RESPONSE;
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b1;
          end
        end
        RESPONSE: begin
          if (i_response_ready) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_request_ready  = (state_reg == IDLE);
  assign o_valid          = valid_reg;
  assign o_data           = data_reg;
  assign o_response_valid = resp_valid_reg;
  assign o_response_data  = resp_data_reg;
  assign o_response_error = resp_err_reg;

endmodule
